// File: rtl/div_iter_param.sv
// Iterative restoring divider, WIDTH-bit operands, BPC quotient bits per cycle.
// Signed operation works on magnitudes; signs are re-applied in a final FIX cycle.
module div_iter_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   ret_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 dbz_o
);

  localparam int unsigned N  = WIDTH / BPC;
  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic                 sign1_q, sign1_d;
  logic                 sign2_q, sign2_d;
  logic [2*WIDTH-1:0]   ret_q, ret_d;
  logic                 ready_q, ready_d;
  logic                 dbz_q, dbz_d;

  logic                 neg1, neg2;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH-1:0]     step_rem, step_quo;
  logic [WIDTH:0]       shifted, trial;

  assign neg1 = signed_div_i & opdata1_i[WIDTH-1];
  assign neg2 = signed_div_i & opdata2_i[WIDTH-1];
  assign abs1 = neg1 ? -opdata1_i : opdata1_i;
  assign abs2 = neg2 ? -opdata2_i : opdata2_i;

  // The quotient register doubles as the dividend shifter: dividend bits leave
  // at the MSB while quotient bits enter at the LSB.
  always_comb begin
    step_rem = rem_q;
    step_quo = quo_q;
    shifted  = '0;
    trial    = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      shifted  = {step_rem, step_quo[WIDTH-1]};
      trial    = shifted - {1'b0, dvsr_q};
      step_quo = {step_quo[WIDTH-2:0], ~trial[WIDTH]};
      step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    ret_d   = ret_q;
    ready_d = ready_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        ret_d   = '0;
        ready_d = 1'b0;
        dbz_d   = 1'b0;
        if (start_i && !annul_i) begin
          sign1_d = neg1;
          sign2_d = neg2;
          dvsr_d  = abs2;
          quo_d   = abs1;
          rem_d   = '0;
          cnt_d   = '0;
          if (opdata2_i == '0) begin
            // ready_o rises on the following edge from the DONE state.
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          ret_d   = {(sign1_q ? -rem_q : rem_q),
                     ((sign1_q ^ sign2_q) ? -quo_q : quo_q)};
          ready_d = 1'b1;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start_i) begin
          ret_d   = '0;
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      ret_q   <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      ret_q   <= ret_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ret_o   = ret_q;
  assign ready_o = ready_q;
  assign dbz_o   = dbz_q;
  assign busy_o  = (state_q == S_BUSY) || (state_q == S_FIX);

endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param at BPC = 1, 2 and 4 with an expected-result
// queue filled when a division is launched and drained when ready_o rises.
module tb_div_iter_param;
  localparam int W = 32;

  typedef struct {
    logic [2*W-1:0] ret;
    logic           dbz;
    int             lat;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nerr = 0;

  logic           clk = 1'b0;
  logic           rst;
  logic           sgn;
  logic [W-1:0]   a, b;
  logic [2:0]     st;
  logic           annul;
  int             sel;

  logic [2*W-1:0] ret1, ret2, ret4, ret_s;
  logic           rdy1, rdy2, rdy4, rdy_s;
  logic           bsy1, bsy2, bsy4, bsy_s;
  logic           dbz1, dbz2, dbz4, dbz_s;

  always #5 clk = ~clk;

  div_iter_param #(.WIDTH(W), .BPC(1)) u1 (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .start_i(st[0]), .annul_i(annul), .ret_o(ret1), .ready_o(rdy1),
    .busy_o(bsy1), .dbz_o(dbz1));
  div_iter_param #(.WIDTH(W), .BPC(2)) u2 (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .start_i(st[1]), .annul_i(annul), .ret_o(ret2), .ready_o(rdy2),
    .busy_o(bsy2), .dbz_o(dbz2));
  div_iter_param #(.WIDTH(W), .BPC(4)) u4 (
    .clk(clk), .rst(rst), .signed_div_i(sgn), .opdata1_i(a), .opdata2_i(b),
    .start_i(st[2]), .annul_i(annul), .ret_o(ret4), .ready_o(rdy4),
    .busy_o(bsy4), .dbz_o(dbz4));

  always_comb begin
    ret_s = ret1; rdy_s = rdy1; bsy_s = bsy1; dbz_s = dbz1;
    case (sel)
      1: begin ret_s = ret2; rdy_s = rdy2; bsy_s = bsy2; dbz_s = dbz2; end
      2: begin ret_s = ret4; rdy_s = rdy4; bsy_s = bsy4; dbz_s = dbz4; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
    ncmp++;
    assert (act === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic run_div(input int s, input logic sg, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input logic ed, input string tag);
    exp_t e;
    int   bpc;
    int   lat;
    bit   got;
    bpc   = (s == 0) ? 1 : (s == 1) ? 2 : 4;
    e.ret = {er, eq};
    e.dbz = ed;
    e.lat = ed ? 1 : (W / bpc) + 1;
    sb.push_back(e);

    @(negedge clk);
    sel = s; sgn = sg; a = x; b = y; annul = 1'b0; st = '0; st[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = $urandom; b = $urandom; sgn = ~sg;
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clk); #1;
      if (c == 1) check({tag, "_busy"}, 64'(bsy_s), 64'(!ed));
      if (rdy_s) begin got = 1'b1; lat = c; end
    end
    e = sb.pop_front();
    check({tag, "_ready_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_ret"}, ret_s, e.ret);
      check({tag, "_dbz"}, 64'(dbz_s), 64'(e.dbz));
      check({tag, "_latency"}, 64'(lat), 64'(e.lat));
      @(posedge clk); #1;
      check({tag, "_hold_ready"}, 64'(rdy_s), 64'd1);
      check({tag, "_hold_ret"}, ret_s, e.ret);
    end
    @(negedge clk);
    st = '0;
    @(posedge clk); #1;
    check({tag, "_clr_ready"}, 64'(rdy_s), 64'd0);
    check({tag, "_clr_ret"}, ret_s, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rx, ry;
    rst = 1'b1; sgn = 1'b0; a = '0; b = '0; st = '0; annul = 1'b0; sel = 0;
    #12;
    check("rst_ready", 64'(rdy_s), 64'd0);
    check("rst_ret", ret_s, 64'd0);
    check("rst_busy", 64'(bsy_s), 64'd0);
    check("rst_dbz", 64'(dbz_s), 64'd0);
    rst = 1'b0;

    run_div(0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "u100_7");
    run_div(0, 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "sm7_2");
    run_div(0, 1'b1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 1'b0, "s7_m2");
    run_div(0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, "smin_m1");
    run_div(0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, "umax_1");
    run_div(1, 1'b0, 32'hFFFFFFFF, 32'h3, 32'h55555555, 32'h0, 1'b0, "b2_max_3");
    run_div(2, 1'b0, 32'hFFFFFFFF, 32'h3, 32'h55555555, 32'h0, 1'b0, "b4_max_3");
    run_div(0, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, "u_dbz");
    run_div(0, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "after_dbz");
    run_div(0, 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, "s_dbz");
    run_div(2, 1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 1'b1, "b4_dbz");

    // Annul in the middle of BUSY, start still held
    @(negedge clk);
    sel = 0; sgn = 1'b0; a = 32'd1000; b = 32'd3; st = 3'b001; annul = 1'b0;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk); #1;
    check("annul_busy", 64'(bsy_s), 64'd0);
    check("annul_ready", 64'(rdy_s), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("annul_held_ready", 64'(rdy_s), 64'd0);
    end
    run_div(0, 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, "after_annul");

    // Asynchronous reset between clock edges while BUSY
    @(negedge clk);
    sel = 0; sgn = 1'b0; a = 32'd12345; b = 32'd7; st = 3'b001;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_busy", 64'(bsy_s), 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(bsy_s), 64'd0);
    check("async_rst_ready", 64'(rdy_s), 64'd0);
    check("async_rst_ret", ret_s, 64'd0);
    st = '0;
    #2 rst = 1'b0;
    run_div(0, 1'b0, 32'd12345, 32'd7, 32'd1763, 32'd4, 1'b0, "after_rst");

    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 2; k++) begin
        rx = $urandom;
        ry = ($urandom >> $urandom_range(0, 31)) | 32'd1;
        run_div(s, 1'b0, rx, ry, rx / ry, rx % ry, 1'b0, "rand_u");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/div_iter_param.md
Name: div_iter_param

Overview:
- Parametrised iterative restoring divider for the execute stage. It is the successor of the fixed 32-bit, 1-bit-per-cycle divider.
- Generalised in operand width and in quotient bits retired per cycle (radix 2/4/16).
- Adds an explicit divide-by-zero flag and a busy indication.
- Latches signedness and operand signs at start, so the upstream pipeline may change operands while a division is in flight.

Parameters:
- WIDTH, 32, operand width in bits. Must be divisible by BPC and be at least 4.
- BPC, 1, quotient bits produced per cycle. Legal values are 1, 2 and 4. Each cycle chains BPC restoring steps combinationally.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- signed_div_i  in  1  1 = two's-complement division, 0 = unsigned.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request. Level-held by the requester until the result has been consumed.
- annul_i  in  1  cancel request, e.g. on flush or exception.
- ret_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- ready_o  out  1  result valid.
- busy_o  out  1  high in the BUSY and FIX states.
- dbz_o  out  1  qualified by ready_o. 1 = the divisor was zero.

Behaviour:
- Reset (async, rst=1): state=IDLE, ret_o=0, ready_o=0, busy_o=0, dbz_o=0, counter=0. Internal operand registers clear to 0. Reset mid-operation abandons the division immediately.
- States: IDLE, BUSY, FIX, DONE. N = WIDTH/BPC iterations.
- IDLE
  - Accept when start_i=1 and annul_i=0. Edge E0 is the accept edge.
  - Latch: the signed flag, sign1 = signed & op1[MSB], sign2 = signed & op2[MSB].
  - Latch the magnitudes |op1| and |op2|. In unsigned mode these are the raw operands.
  - If op2=0: go to DONE with ret_o=0 and dbz_o=1. ready_o is high after E1, i.e. the DONE state's registered outputs are set on E1.
  - Otherwise: go to BUSY, clear the partial remainder, place |op1| in the quotient shift register, counter=0.
  - With start_i=0, or with annul_i=1, hold ret_o=0 and ready_o=0.
- BUSY (edges E1..EN)
  - Each edge performs BPC restoring steps, MSB-first.
  - Per step: trial = {rem, next dividend bit} - {0, divisor}, computed at WIDTH+1 bits.
  - If trial is non-negative: rem takes trial and the quotient bit is 1. Otherwise rem takes the shifted value and the quotient bit is 0.
  - Increment the counter. After edge EN (counter reaches N), go to FIX.
- FIX (edge EN+1)
  - If sign1^sign2, negate the quotient.
  - If sign1, negate the remainder, so the remainder takes the sign of the dividend.
  - Register ret_o, set ready_o=1 and dbz_o=0, go to DONE.
  - Result: ready_o is first high after EN+1 edges following E0. This is 33 for WIDTH=32/BPC=1 and 17 for BPC=2.
- DONE
  - Hold ret_o, ready_o and dbz_o while start_i=1.
  - When start_i=0 on an edge: go to IDLE, ready_o=0, dbz_o=0, ret_o=0.
  - annul_i is ignored in DONE.
- Annul: annul_i=1 in BUSY or FIX goes to IDLE on the next edge. ready_o stays 0 and ret_o stays 0. A pending start_i=1 in that IDLE cycle is re-accepted only if annul_i=0.
- Arithmetic corner cases:
  - Signed MIN / -1 gives quotient = MIN (wraps) and remainder 0, with no flag.
  - Unsigned MAX / 1 gives quotient = MAX and remainder 0.
  - Magnitude of MIN is MIN, interpreted as unsigned, which is exact.
- Operands are read only at E0. Changes to opdata*_i or signed_div_i during BUSY, FIX or DONE have no effect.
- busy_o is combinational from state. ready_o and ret_o are registered.
- Counter width: clog2(N+1).

Test Plan:
- WIDTH=32, BPC=1, unsigned 100/7 -> after 33 edges: ready_o=1, ret_o={32'd2, 32'd14}, dbz_o=0. Holds while start_i=1; start_i=0 -> next edge ready_o=0, ret_o=0.
- Signed -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x1. Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- BPC=2 and BPC=4, unsigned 0xFFFFFFFF/0x3 -> quotient 0x55555555, remainder 0. ready_o after 17 and 9 edges respectively.
- Divide by zero, 5/0 (both modes) -> ready_o=1 after E1, dbz_o=1, ret_o=0. The next division 9/3 gives dbz_o=0 and quotient 3.
- Annul raised at BUSY iteration 10 -> IDLE next edge, ready_o never asserts. Then start 50/5 with annul_i=0 -> quotient 10, remainder 0 at the nominal latency.
- Async rst pulse mid-BUSY, between clock edges -> outputs 0 immediately, state IDLE. Operands changed during BUSY -> result matches the operands latched at E0.
